// File: rtl/lock_digit_entry.sv
// Input stage for the combination lock: synchronises the switches and the digit
// button, debounces the button and turns each press into one positioned digit strobe.
module lock_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SEQ_LEN         = 6,
  parameter int TIMEOUT_CYCLES  = 250000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] sw_i,
  input  logic       key_n_i,
  output logic [3:0] digit_o,
  output logic       digit_valid_o,
  output logic       digit_err_o,
  output logic [2:0] digit_pos_o,
  output logic       seq_done_o,
  output logic       abort_o,
  output logic       key_held_o
);

  localparam int CntW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TmrW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      PosLast = 3'(SEQ_LEN - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  logic            keySync1_q, keySync2_q;
  logic [3:0]      swSync1_q, swSync2_q;
  state_t          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [2:0]      posCnt_q, posCnt_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic            accept, timeout;
  logic [3:0]      digit_q;
  logic            digitValid_q, digitErr_q, seqDone_q, abort_q;
  logic [2:0]      digitPos_q;

  // The key flops preset to released so a key held through reset reads as a fresh press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      keySync1_q <= 1'b1;
      keySync2_q <= 1'b1;
      swSync1_q  <= '0;
      swSync2_q  <= '0;
    end else begin
      keySync1_q <= key_n_i;
      keySync2_q <= keySync1_q;
      swSync1_q  <= sw_i;
      swSync2_q  <= swSync1_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      count_q  <= '0;
      posCnt_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      posCnt_q <= posCnt_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!keySync2_q) begin
          state_d = PRESS_WAIT;
          count_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (keySync2_q) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == CntLast) begin
          state_d = PRESSED;
          count_d = '0;
          accept  = 1'b1;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      PRESSED: begin
        if (keySync2_q) begin
          state_d = RELEASE_WAIT;
          count_d = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!keySync2_q) begin
          state_d = PRESSED;
          count_d = '0;
        end else if (count_q == CntLast) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // An accept on the timeout edge takes priority, so the entry is never aborted under a new digit.
  always_comb begin
    posCnt_d = posCnt_q;
    timer_d  = timer_q;
    timeout  = 1'b0;
    if (accept) begin
      timer_d  = '0;
      posCnt_d = (posCnt_q == PosLast) ? 3'd0 : posCnt_q + 3'd1;
    end else if (posCnt_q != 3'd0) begin
      if (timer_q == TmrLast) begin
        timeout  = 1'b1;
        posCnt_d = 3'd0;
        timer_d  = '0;
      end else begin
        timer_d = timer_q + TmrW'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q      <= '0;
      digitValid_q <= 1'b0;
      digitErr_q   <= 1'b0;
      digitPos_q   <= '0;
      seqDone_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      digitValid_q <= accept;
      seqDone_q    <= accept && (posCnt_q == PosLast);
      abort_q      <= timeout;
      if (accept) begin
        digit_q    <= swSync2_q;
        digitErr_q <= (swSync2_q > 4'd9);
        digitPos_q <= posCnt_q;
      end
    end
  end

  assign digit_o       = digit_q;
  assign digit_valid_o = digitValid_q;
  assign digit_err_o   = digitErr_q;
  assign digit_pos_o   = digitPos_q;
  assign seq_done_o    = seqDone_q;
  assign abort_o       = abort_q;
  assign key_held_o    = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: tb/tb_lock_digit_entry.sv
// Bench for lock_digit_entry: random and scripted key/switch activity compared every
// cycle against a level-and-run-length model of the debounced button.
module tb_lock_digit_entry;

  localparam int DC = 4;
  localparam int TO = 40;
  localparam int SL = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       keyN;
  logic [3:0] sw;
  logic [3:0] digit;
  logic       digitValid, digitErr, seqDone, abortP, keyHeld;
  logic [2:0] digitPos;

  int vectorCount = 0;
  int missCount   = 0;

  logic       k1, k2;
  logic [3:0] s1, s2;
  bit         debDown;
  int         run, pos, idle;
  logic [3:0] expDigit;
  logic       expValid, expErr, expDone, expAbort;
  logic [2:0] expPos;

  always #5 clk = ~clk;

  lock_digit_entry #(
    .DEBOUNCE_CYCLES(DC),
    .SEQ_LEN(SL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .sw_i(sw),
    .key_n_i(keyN),
    .digit_o(digit),
    .digit_valid_o(digitValid),
    .digit_err_o(digitErr),
    .digit_pos_o(digitPos),
    .seq_done_o(seqDone),
    .abort_o(abortP),
    .key_held_o(keyHeld)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // The debounced level flips once DC+1 consecutive synchronised samples disagree with it.
  function automatic void modelStep(input logic rstV, input logic keyV, input logic [3:0] swV);
    logic       syncKey;
    logic [3:0] syncSw;
    bit         downNow;
    bit         accept;
    if (rstV) begin
      k1 = 1'b1; k2 = 1'b1; s1 = '0; s2 = '0;
      debDown = 1'b0; run = 0; pos = 0; idle = 0;
      expDigit = '0; expValid = 1'b0; expErr = 1'b0; expPos = '0;
      expDone = 1'b0; expAbort = 1'b0;
      return;
    end
    syncKey = k2;
    syncSw  = s2;
    k2 = k1; k1 = keyV;
    s2 = s1; s1 = swV;
    expValid = 1'b0; expDone = 1'b0; expAbort = 1'b0;
    accept  = 1'b0;
    downNow = !syncKey;
    if (downNow != debDown) begin
      run++;
      if (run == DC + 1) begin
        debDown = downNow;
        run     = 0;
        accept  = downNow;
      end
    end else begin
      run = 0;
    end
    if (accept) begin
      expValid = 1'b1;
      expDigit = syncSw;
      expErr   = (syncSw > 9);
      expPos   = 3'(pos);
      expDone  = (pos == SL - 1);
      pos      = (pos + 1) % SL;
      idle     = 0;
    end else if (pos != 0) begin
      idle++;
      if (idle == TO) begin
        expAbort = 1'b1;
        pos      = 0;
        idle     = 0;
      end
    end else begin
      idle = 0;
    end
  endfunction

  task automatic applyStimulus(input logic rstV, input logic keyV, input logic [3:0] swV);
    rst  = rstV;
    keyN = keyV;
    sw   = swV;
    @(posedge clk);
    modelStep(rstV, keyV, swV);
    @(negedge clk);
    checkOutput("digit_valid", 32'(digitValid), 32'(expValid));
    checkOutput("digit", 32'(digit), 32'(expDigit));
    checkOutput("digit_err", 32'(digitErr), 32'(expErr));
    checkOutput("digit_pos", 32'(digitPos), 32'(expPos));
    checkOutput("seq_done", 32'(seqDone), 32'(expDone));
    checkOutput("abort", 32'(abortP), 32'(expAbort));
    checkOutput("key_held", 32'(keyHeld), 32'(debDown));
  endtask

  task automatic pressClean(input logic [3:0] swV, input int lowLen, input int highLen);
    for (int i = 0; i < lowLen; i++) applyStimulus(1'b0, 1'b0, swV);
    for (int i = 0; i < highLen; i++) applyStimulus(1'b0, 1'b1, swV);
  endtask

  task automatic pressBouncy(input logic [3:0] swV);
    for (int b = 0; b < 4; b++) begin
      int segLen;
      segLen = $urandom_range(1, 3);
      for (int i = 0; i < segLen; i++) applyStimulus(1'b0, b[0], swV);
    end
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, swV);
    for (int b = 0; b < 4; b++) begin
      int segLen;
      segLen = $urandom_range(1, 3);
      for (int i = 0; i < segLen; i++) applyStimulus(1'b0, ~b[0], swV);
    end
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, swV);
  endtask

  initial begin
    logic [3:0] seqVals [7];
    seqVals = '{4'd9, 4'd4, 4'd6, 4'd2, 4'd2, 4'd2, 4'd11};
    rst = 1'b1; keyN = 1'b1; sw = '0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'($urandom_range(0, 15)));

    // Full combination, wrap into the next entry and an out-of-range digit.
    for (int d = 0; d < 7; d++) pressClean(seqVals[d], 10, 12 + $urandom_range(0, 4));
    pressClean(4'($urandom_range(0, 15)), $urandom_range(6, 20), 12);

    for (int n = 0; n < 6; n++) pressBouncy(4'($urandom_range(0, 15)));

    // Two digits then idle long enough to abort, then idle with nothing pending.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 4'd0);
    pressClean(4'($urandom_range(0, 15)), 10, 12);
    pressClean(4'($urandom_range(0, 15)), 10, 12);
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1, 4'($urandom_range(0, 15)));

    // Second press lands its accept on the very edge the timer would expire.
    pressClean(4'd3, 10, 30);
    pressClean(4'd5, 10, 12);
    for (int i = 0; i < 50; i++) applyStimulus(1'b0, 1'b1, 4'd0);

    // Reset during PRESS_WAIT after three digits, key held through and beyond reset.
    for (int d = 0; d < 3; d++) pressClean(4'($urandom_range(0, 15)), 10, 12);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 4'd7);
    applyStimulus(1'b1, 1'b0, 4'd7);
    pressClean(4'd7, 12, 14);

    for (int seg = 0; seg < 200; seg++) begin
      int   segLen;
      logic keyV;
      segLen = $urandom_range(1, 14);
      keyV   = 1'($urandom_range(0, 1));
      for (int i = 0; i < segLen; i++)
        applyStimulus(($urandom_range(0, 149) == 0), keyV, 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/lock_digit_entry.md
Name: lock_digit_entry

Overview:
- Upstream input stage for the combination-lock FSM. Synchronises the switch bank and the raw active-low digit-entry push button, then debounces the button.
- Each debounced press becomes a single one-cycle digit strobe. The strobe carries the captured switch value, a >9 error flag and the digit's position in the SEQ_LEN-digit combination.
- An inactivity timer aborts a partly entered combination. The lock FSM consumes digit_valid/digit/digit_err/seq_done/abort directly.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles the button must be stable before a press or release is accepted (10 ms at 50 MHz); minimum 2.
- SEQ_LEN, 6, digits per combination.
- TIMEOUT_CYCLES, 250000000, idle cycles after the last accepted digit before the partial entry is aborted (5 s at 50 MHz).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw  input  4  raw switch value, asynchronous to clk.
- key_n  input  1  raw digit-entry push button, active-low, bouncing, asynchronous.
- digit  output  4  switch value captured with the current strobe; holds until the next strobe.
- digit_valid  output  1  one-cycle strobe, one per debounced press.
- digit_err  output  1  valid with digit_valid; 1 when the captured value is >9.
- digit_pos  output  3  0-based position of the strobed digit within the combination.
- seq_done  output  1  one-cycle pulse coincident with the strobe of position SEQ_LEN-1.
- abort  output  1  one-cycle pulse on inactivity timeout.
- key_held  output  1  1 while the debouncer is in PRESSED or RELEASE_WAIT (LED indication).

Behaviour:
- Synchronisers
  - Two-flop synchronisers on key_n and on each sw bit.
  - On reset the key_n flops preset to 1 (released) and the sw flops clear to 0.
- Debounce FSM: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; count register is 0 on state entry.
  - IDLE: synced key low -> PRESS_WAIT.
  - PRESS_WAIT: synced key high -> IDLE (bounce, no strobe). Otherwise increment count. When count reaches DEBOUNCE_CYCLES-1 -> PRESSED and raise the accept event.
  - PRESSED: synced key high -> RELEASE_WAIT.
  - RELEASE_WAIT: synced key low -> PRESSED (release bounce, no new strobe). Otherwise count. At DEBOUNCE_CYCLES-1 -> IDLE.
- Accept event (registered outputs, all take effect on the same edge)
  - digit_valid=1 for exactly one cycle.
  - digit <= synced sw; digit_err <= (synced sw > 9).
  - digit_pos <= pos_cnt.
  - seq_done=1 iff pos_cnt==SEQ_LEN-1.
  - pos_cnt increments, wrapping SEQ_LEN-1 -> 0.
- Latency: let edge N be the first edge at which the first synchroniser flop samples key_n low, with key_n held low from then on. digit_valid is high in the cycle following edge N+DEBOUNCE_CYCLES+2.
- Error digits are forwarded and counted toward position; wrong-digit policy belongs to the lock FSM.
- Inactivity timer
  - Runs only while pos_cnt != 0 and clears on every accept.
  - When it reaches TIMEOUT_CYCLES-1: abort=1 for one cycle, pos_cnt <= 0, timer clears.
  - Accept and timeout on the same edge: the accept wins; no abort, timer cleared, pos_cnt advances normally.
- Reset
  - Values: digit=0, digit_valid=0, digit_err=0, digit_pos=0, seq_done=0, abort=0, key_held=0, pos_cnt=0, timer=0, FSM=IDLE.
  - Reset mid-debounce or mid-combination discards all progress.
  - A key still held when rst deasserts is treated as a fresh press: exactly one strobe after the full debounce latency.
- Only one strobe per physical press, regardless of release bounce or press duration.

Test Plan:
All scenarios override DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=40.
- Clean press, sw=9, key_n low 10 cycles then high -> one digit_valid pulse at N+6 (cycle after edge N+4+2), digit=9, digit_err=0, digit_pos=0; no second pulse on release.
- Bouncy press: key_n toggles low/high every 2 cycles for 8 cycles, then stays low, with sw=4 -> exactly one strobe, 6 cycles after the final stable low is first sampled, digit=4.
- Full sequence 9,4,6,2,2,2, each a clean press with >=12-cycle gaps -> digit_pos 0..5 on successive strobes; seq_done only with the 6th; next press reports digit_pos=0.
- sw=11, clean press -> digit=11, digit_err=1, digit_pos advances to 1 for the next strobe.
- Enter two digits, then idle -> abort pulse exactly TIMEOUT_CYCLES cycles after the 2nd strobe; next digit has digit_pos=0. With pos_cnt=0 and idle -> abort never asserts.
- Assert rst for 1 cycle midway through PRESS_WAIT and after 3 digits, key still low -> all outputs 0; one fresh strobe with digit_pos=0 after the full debounce latency.
